// File: rtl/wb_pkg.sv
// Shared types for the Wishbone round-robin arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    typedef enum logic {
        RETURN_ACK = 1'b0,
        RETURN_ERR = 1'b1
    } ret_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin priority encoder: first requester searching upward from last+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        // offset N wraps back onto last itself, so a lone requester is re-granted
        for (int off = 1; off <= N; off++) begin
            if (!vld && req[(int'(last) + off) % N]) begin
                vld                          = 1'b1;
                gnt[(int'(last) + off) % N]  = 1'b1;
                idx                          = IW'((int'(last) + off) % N);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Shares one Wishbone B4 slave among NUM_MASTERS masters, round-robin, owner holds for whole CYC.
// Latency: 1 cycle IDLE->grant; address/data/strobe paths add zero cycles once owned.
// Backpressure: slave ACK/ERR routed only to owner; watchdog aborts stalled strobes with ERR.
module wb_arbiter_rr
    import wb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 32,
    parameter  int GRANULE     = 8,
    parameter  int TIMEOUT     = 16,
    localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE,
    localparam int IW          = idx_width(NUM_MASTERS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          gidx_q;
    logic [IW-1:0]          last_q;
    logic [WD_W-1:0]        wd_q;
    logic                   pending_q;
    logic                   err_pulse_q;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_vld;
    logic                   owned;
    logic                   slv_ret;

    wb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    assign owned   = (state_q == OWNED);
    assign slv_ret = s_ack_i | s_err_i;

    // slave-side request: straight mux from the owner's slice, no register stage
    assign s_cyc_o = owned & m_cyc_i[gidx_q];
    assign s_stb_o = owned & m_stb_i[gidx_q];
    assign s_we_o  = owned & m_we_i[gidx_q];
    assign s_adr_o = m_adr_i[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_o = m_dat_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign s_sel_o = m_sel_i[gidx_q*SEL_WIDTH +: SEL_WIDTH];

    // grant_q is zero outside OWNED/ABORT, so responses can never leak to other masters
    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_q & {NUM_MASTERS{owned & s_ack_i}};
    assign m_err_o = grant_q & {NUM_MASTERS{(owned & s_err_i) | err_pulse_q}};
    assign grant_o = grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_q      <= IW'(NUM_MASTERS - 1);
            wd_q        <= '0;
            pending_q   <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    wd_q      <= '0;
                    pending_q <= 1'b0;
                    if (pick_vld) begin
                        state_q <= OWNED;
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                    end
                end

                OWNED: begin
                    if (!m_cyc_i[gidx_q]) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        last_q    <= gidx_q;
                        wd_q      <= '0;
                        pending_q <= 1'b0;
                    end else begin
                        if (slv_ret) begin
                            pending_q <= 1'b0;
                        end else if (s_stb_o) begin
                            pending_q <= 1'b1;
                        end

                        if (TIMEOUT > 0) begin
                            if (slv_ret) begin
                                wd_q <= '0;
                            end else if (m_stb_i[gidx_q] || pending_q) begin
                                if (wd_q == WD_LAST) begin
                                    state_q     <= ABORT;
                                    err_pulse_q <= 1'b1;
                                    wd_q        <= '0;
                                    pending_q   <= 1'b0;
                                end else begin
                                    wd_q <= wd_q + 1'b1;
                                end
                            end
                        end
                    end
                end

                ABORT: begin
                    // slave stays detached; wait for the owner to give up CYC
                    if (!m_cyc_i[gidx_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= gidx_q;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr with a behavioural slave and a response scoreboard.
module tb_wb_arbiter_rr;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0;
    logic            s_err_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        bit          rd;
        logic [31:0] d;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] ref_mem [16];

    always #5 clk_i = ~clk_i;

    wb_arbiter_rr #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .GRANULE     (8),
        .TIMEOUT     (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    // Behavioural slave: register file, ack latency slv_lat cycles after the accepting edge (0 = never).
    int          slv_lat = 1;
    logic        slv_busy = 1'b0;
    int          slv_cnt = 0;
    logic [31:0] smem [16] = '{default: '0};

    assign s_err_i = 1'b0;

    always @(posedge clk_i) begin
        s_ack_i <= 1'b0;
        if (slv_busy) begin
            if (slv_cnt <= 1) begin
                s_ack_i  <= 1'b1;
                slv_busy <= 1'b0;
            end else begin
                slv_cnt <= slv_cnt - 1;
            end
        end else if (s_cyc_o && s_stb_o && !s_ack_i && slv_lat > 0) begin
            if (s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel_o[b]) smem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
            end
            s_dat_i <= smem[s_adr_o[5:2]];
            if (slv_lat == 1) begin
                s_ack_i <= 1'b1;
            end else begin
                slv_busy <= 1'b1;
                slv_cnt  <= slv_lat - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_bus(input int m, input bit we, input logic [15:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        m_we_i[m]            = we;
        m_adr_i[m*AW +: AW]  = adr;
        m_dat_i[m*DW +: DW]  = dat;
        m_sel_i[m*SW +: SW]  = sel;
        m_cyc_i[m]           = 1'b1;
        m_stb_i[m]           = 1'b1;
    endtask

    task automatic push_exp(input int m, input bit we, input logic [15:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        exp_t e;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
        end
        e.m  = m;
        e.rd = !we;
        e.d  = ref_mem[adr[5:2]];
        sb_q.push_back(e);
    endtask

    task automatic issue(input int m, input bit we, input logic [15:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        set_bus(m, we, adr, dat, sel);
        push_exp(m, we, adr, dat, sel);
    endtask

    // Waits for the owner's ACK, checking no other master sees a response meanwhile.
    task automatic wait_ack(input int m, output int ncyc);
        bit           got;
        logic [N-1:0] msk;
        exp_t         e;
        got  = 1'b0;
        ncyc = 0;
        msk  = '0;
        msk[m] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            ncyc++;
            check("stray_ack", m_ack_o & ~msk, '0);
            if (m_ack_o[m]) begin
                got = 1'b1;
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("ack_master", m, e.m);
                    if (e.rd) check("rd_data", m_dat_o, e.d);
                end
                m_stb_i[m] = 1'b0;
            end
        end
        check("ack_seen", got, 1);
    endtask

    task automatic race();
        int n;
        issue(0, 1'b0, 16'h0004, 32'h0, 4'hF);
        issue(1, 1'b0, 16'h0004, 32'h0, 4'hF);
        tick();
        check("race_first_grant", grant_o, 2'b01);
        wait_ack(0, n);
        m_cyc_i[0] = 1'b0;
        tick();
        check("race_gap_cyc", s_cyc_o, 0);
        check("race_gap_grant", grant_o, 2'b00);
        wait_ack(1, n);
        check("race_second_grant", grant_o, 2'b10);
        m_cyc_i[1] = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int stb_cnt;
        bit got;

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        repeat (3) tick();
        check("rst_cyc", s_cyc_o, 0);
        check("rst_stb", s_stb_o, 0);
        check("rst_we", s_we_o, 0);
        check("rst_grant", grant_o, '0);
        check("rst_ack", m_ack_o, '0);
        check("rst_err", m_err_o, '0);
        rst_i = 1'b0;
        tick();

        // M0 classic write then M1 classic read of the same word
        issue(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
        wait_ack(0, n);
        check("wr_latency", n, 2);
        check("wr_grant", grant_o, 2'b01);
        m_cyc_i[0] = 1'b0;
        tick();
        check("handover_gap", s_cyc_o, 0);
        issue(1, 1'b0, 16'h0004, 32'h0, 4'hF);
        wait_ack(1, n);
        check("rd_grant", grant_o, 2'b10);
        m_cyc_i[1] = 1'b0;
        tick();

        // simultaneous requests, twice: M0 then M1 each time
        race();
        race();

        // M0 read-modify-write holds the bus while M1 waits
        issue(0, 1'b0, 16'h0008, 32'h0, 4'hF);
        wait_ack(0, n);
        set_bus(1, 1'b0, 16'h0008, 32'h0, 4'hF);
        tick();
        check("rmw_hold_grant", grant_o, 2'b01);
        check("rmw_idle_stb", s_stb_o, 0);
        issue(0, 1'b1, 16'h0008, 32'h12345678, 4'hF);
        wait_ack(0, n);
        check("rmw_still_owned", grant_o, 2'b01);
        push_exp(1, 1'b0, 16'h0008, 32'h0, 4'hF);
        m_cyc_i[0] = 1'b0;
        wait_ack(1, n);
        check("rmw_m1_grant", grant_o, 2'b10);
        m_cyc_i[1] = 1'b0;
        tick();

        // M1 pipelined read: one strobe cycle, ack two cycles later
        slv_lat = 2;
        issue(1, 1'b0, 16'h0004, 32'h0, 4'hF);
        tick();
        check("pipe_stb", s_stb_o, 1);
        tick();
        m_stb_i[1] = 1'b0;
        wait_ack(1, n);
        check("pipe_ack_delay", n, 1);
        m_cyc_i[1] = 1'b0;
        tick();

        // slave never answers: watchdog aborts M0, then M1 gets the bus
        slv_lat = 0;
        set_bus(0, 1'b0, 16'h0000, 32'h0, 4'hF);
        issue(1, 1'b0, 16'h0004, 32'h0, 4'hF);
        stb_cnt = 0;
        got     = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            check("wd_no_ack", m_ack_o, '0);
            if (m_err_o != '0) got = 1'b1;
            else if (s_stb_o) stb_cnt++;
        end
        check("wd_fired", got, 1);
        check("wd_err_vec", m_err_o, 2'b01);
        check("wd_stb_cycles", stb_cnt, 16);
        check("wd_abort_cyc", s_cyc_o, 0);
        tick();
        check("wd_err_one_cycle", m_err_o, '0);
        check("wd_abort_cyc_hold", s_cyc_o, 0);
        check("wd_abort_grant", grant_o, 2'b01);
        slv_lat = 1;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        tick();
        check("wd_release_idle", grant_o, 2'b00);
        wait_ack(1, n);
        check("wd_next_grant", grant_o, 2'b10);
        m_cyc_i[1] = 1'b0;
        tick();

        // reset while M0 write has an ack in flight
        slv_lat = 2;
        set_bus(0, 1'b1, 16'h000C, 32'hCAFEF00D, 4'hF);
        tick();
        check("rst_mid_owned", grant_o, 2'b01);
        tick();
        rst_i = 1'b1;
        tick();
        check("rst_mid_cyc", s_cyc_o, 0);
        check("rst_mid_grant", grant_o, '0);
        check("rst_mid_ack", m_ack_o, '0);
        check("rst_mid_err", m_err_o, '0);
        rst_i = 1'b0;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        tick();
        check("rst_after_ack", m_ack_o, '0);
        check("rst_after_cyc", s_cyc_o, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
